// File: rtl/niosinst_mult_cell_pipe.sv
// niosinst_mult_cell_pipe
// Pipelined DATA_W x DATA_W multiplier cell for the Nios II custom-instruction
// datapath. Four unsigned half-width partial products are formed at capture
// and carried through PIPE_STAGES register stages. A registered combine stage
// adds them and applies two's-complement correction per operand. The result
// is the full 2*DATA_W hi:lo product.
// Optional build macro: NIOSINST_MULT_CELL_FLUSH_EN adds a synchronous flush
// input that clears every valid bit.
module niosinst_mult_cell_pipe #(
  parameter int DATA_W      = 32,
  parameter int PIPE_STAGES = 2,
  parameter int RESET_OUT   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  input  logic              src1_signed,
  input  logic              src2_signed,
`ifdef NIOSINST_MULT_CELL_FLUSH_EN
  input  logic              flush,
`endif
  output logic              out_valid,
  output logic [DATA_W-1:0] out_lo,
  output logic [DATA_W-1:0] out_hi,
  output logic              busy
);

  localparam int HALF_W = DATA_W / 2;
  // stage word layout: pp_ll | pp_lh | pp_hl | pp_hh | a | b | a_neg | b_neg
  localparam int STG_W  = 6 * DATA_W + 2;

  logic [PIPE_STAGES-1:0] r_vld;
  logic                   r_out_valid;
  logic [STG_W-1:0]       r_stg [PIPE_STAGES];
  logic [DATA_W-1:0]      r_out_lo;
  logic [DATA_W-1:0]      r_out_hi;

  logic [DATA_W-1:0]   w_pp_ll, w_pp_lh, w_pp_hl, w_pp_hh;
  logic [STG_W-1:0]    w_stg0;
  logic [DATA_W-1:0]   w_ll, w_lh, w_hl, w_hh, w_a, w_b;
  logic                w_a_neg, w_b_neg;
  logic [2*DATA_W-1:0] w_sum;
  logic [2*DATA_W-1:0] w_prod;

  // Half-width partial products, zero-extended so each is a full DATA_W product.
  assign w_pp_ll = {{HALF_W{1'b0}}, src1[HALF_W-1:0]}      * {{HALF_W{1'b0}}, src2[HALF_W-1:0]};
  assign w_pp_lh = {{HALF_W{1'b0}}, src1[HALF_W-1:0]}      * {{HALF_W{1'b0}}, src2[DATA_W-1:HALF_W]};
  assign w_pp_hl = {{HALF_W{1'b0}}, src1[DATA_W-1:HALF_W]} * {{HALF_W{1'b0}}, src2[HALF_W-1:0]};
  assign w_pp_hh = {{HALF_W{1'b0}}, src1[DATA_W-1:HALF_W]} * {{HALF_W{1'b0}}, src2[DATA_W-1:HALF_W]};

  assign w_stg0 = {w_pp_ll, w_pp_lh, w_pp_hl, w_pp_hh, src1, src2,
                   src1_signed & src1[DATA_W-1], src2_signed & src2[DATA_W-1]};

  assign {w_ll, w_lh, w_hl, w_hh, w_a, w_b, w_a_neg, w_b_neg} = r_stg[PIPE_STAGES-1];

  // Unsigned product modulo 2^(2*DATA_W). A negative operand was read as
  // value + 2^DATA_W, so subtract the other operand shifted by DATA_W once per
  // negative operand. The cross term 2^(2*DATA_W) drops out of the modulus.
  assign w_sum  = {{DATA_W{1'b0}}, w_ll}
                + {{HALF_W{1'b0}}, w_lh, {HALF_W{1'b0}}}
                + {{HALF_W{1'b0}}, w_hl, {HALF_W{1'b0}}}
                + {w_hh, {DATA_W{1'b0}}};
  assign w_prod = w_sum
                - {w_b & {DATA_W{w_a_neg}}, {DATA_W{1'b0}}}
                - {w_a & {DATA_W{w_b_neg}}, {DATA_W{1'b0}}};

  // Valid chain: cleared by reset (and by flush when built in); advances only when enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld       <= '0;
      r_out_valid <= 1'b0;
    end
`ifdef NIOSINST_MULT_CELL_FLUSH_EN
    else if (flush) begin
      r_vld       <= '0;
      r_out_valid <= 1'b0;
    end
`endif
    else if (en) begin
      r_vld[0] <= in_valid;
      for (int i = 1; i < PIPE_STAGES; i++) r_vld[i] <= r_vld[i-1];
      r_out_valid <= r_vld[PIPE_STAGES-1];
    end
  end

  generate
    if (RESET_OUT != 0) begin : g_data_rst
      // Data pipeline and result registers, cleared on reset.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < PIPE_STAGES; i++) r_stg[i] <= '0;
          r_out_lo <= '0;
          r_out_hi <= '0;
        end else if (en) begin
          r_stg[0] <= w_stg0;
          for (int i = 1; i < PIPE_STAGES; i++) r_stg[i] <= r_stg[i-1];
          if (r_vld[PIPE_STAGES-1]) {r_out_hi, r_out_lo} <= w_prod;
        end
      end
    end else begin : g_data_norst
      // Data pipeline and result registers, not reset. Only the valid chain is cleared.
      always_ff @(posedge clk) begin
        if (en) begin
          r_stg[0] <= w_stg0;
          for (int i = 1; i < PIPE_STAGES; i++) r_stg[i] <= r_stg[i-1];
          if (r_vld[PIPE_STAGES-1]) {r_out_hi, r_out_lo} <= w_prod;
        end
      end
    end
  endgenerate

  assign out_valid = r_out_valid;
  assign out_lo    = r_out_lo;
  assign out_hi    = r_out_hi;
  assign busy      = (|r_vld) | r_out_valid;

endmodule
